// File: rtl/bnn_pkg.sv
// Shared geometry and types for the serial pixel/weight load path.
// The frame and kernel typedefs are also used by the loader on the receive side.
package bnn_pkg;

    localparam int ROWS   = 28;
    localparam int COLS   = 28;
    localparam int N_FILT = 8;
    localparam int K      = 3;
    localparam int NPIX   = ROWS * COLS;
    localparam int NW     = N_FILT * K * K;

    localparam int R_W = $clog2(ROWS);
    localparam int C_W = $clog2(COLS);
    localparam int L_W = $clog2(N_FILT);
    localparam int T_W = $clog2(K);
    localparam int B_W = $clog2(K);

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Digit storage width inside each nested counter
    localparam int PIX_DW = max_w(R_W, C_W);
    localparam int W_DW   = max_w(L_W, max_w(T_W, B_W));

    // pixels[r][c]; c is the fast (LSB) axis
    typedef logic [ROWS-1:0][COLS-1:0] pixel_frame_t;
    // weights[l][t][b]; b is the fast (LSB) axis
    typedef logic [N_FILT-1:0][K-1:0][K-1:0] weight_set_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

endpackage

// File: rtl/nested_counter.sv
// Multi-digit up-counter. Digit 0 is the fastest; each digit rolls over at its
// own LIMIT and carries into the next. With SATURATE set the whole counter
// stops once every digit sits at its limit instead of wrapping to zero.
module nested_counter #(
    parameter int                       NDIG     = 2,
    parameter int                       W        = 4,
    parameter logic [NDIG-1:0][W-1:0]   LIMIT    = '0,
    parameter bit                       SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     adv,
    output logic [NDIG-1:0][W-1:0]   count,
    output logic                     terminal
);

    logic [NDIG-1:0]          at_max;
    logic [NDIG-1:0]          inc;
    logic [NDIG-1:0][W-1:0]   count_next;

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        assign at_max[d] = (count[d] == LIMIT[d]);
        if (d == 0) begin : g_lsd
            assign inc[d] = 1'b1;
        end else begin : g_upper
            // a digit steps only when every faster digit is rolling over
            assign inc[d] = &at_max[d-1:0];
        end
        assign count_next[d] = !inc[d]   ? count[d] :
                               at_max[d] ? '0       : count[d] + 1'b1;
    end

    assign terminal = &at_max;

    // Advance, clear or hold the digit vector
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (adv && !(SATURATE && terminal)) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Bit-serial transmitter for one image plus its kernel set. Pixels leave in
// row-major order on dout_p; weights leave b-fastest, then t, then l, on
// dout_w alongside the first NW pixel bits. Both streams share en_wr.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | ready, outputs quiet, waiting for start
//  SHIFT | presenting one bit per un-held cycle from the snapshots
//  DONE  | one-cycle done pulse; start here chains straight into SHIFT
module frame_serializer
    import bnn_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         hold,
    input  pixel_frame_t pixels_in,
    input  weight_set_t  weights_in,
    output logic         ready,
    output logic         en_wr,
    output logic         dout_p,
    output logic         dout_w,
    output logic         done
);

    ser_state_t                state;
    pixel_frame_t              snap_p;
    weight_set_t               snap_w;
    logic                      pix_last;
    logic                      w_last;

    logic [1:0][PIX_DW-1:0]    pix_cnt;
    logic                      pix_term;
    logic [2:0][W_DW-1:0]      w_cnt;
    logic                      w_term;

    logic [R_W-1:0]            row;
    logic [C_W-1:0]            col;
    logic [L_W-1:0]            lvl;
    logic [T_W-1:0]            trit;
    logic [B_W-1:0]            bit_i;

    logic                      start_ok;
    logic                      shift_bit;
    logic                      unused_cnt_bits;

    assign start_ok  = start && (state != SHIFT);
    // pix_last means bit NPIX-1 is already out; the next edge only closes the frame
    assign shift_bit = (state == SHIFT) && !hold && !pix_last;

    nested_counter #(
        .NDIG     (2),
        .W        (PIX_DW),
        .LIMIT    ({PIX_DW'(ROWS-1), PIX_DW'(COLS-1)}),
        .SATURATE (1'b0)
    ) u_pix_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (start_ok),
        .adv      (shift_bit),
        .count    (pix_cnt),
        .terminal (pix_term)
    );

    nested_counter #(
        .NDIG     (3),
        .W        (W_DW),
        .LIMIT    ({W_DW'(N_FILT-1), W_DW'(K-1), W_DW'(K-1)}),
        .SATURATE (1'b1)
    ) u_w_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (start_ok),
        .adv      (shift_bit && !w_last),
        .count    (w_cnt),
        .terminal (w_term)
    );

    assign row   = pix_cnt[1][R_W-1:0];
    assign col   = pix_cnt[0][C_W-1:0];
    assign lvl   = w_cnt[2][L_W-1:0];
    assign trit  = w_cnt[1][T_W-1:0];
    assign bit_i = w_cnt[0][B_W-1:0];

    // Digits never exceed their limits, so the storage bits above each index are always zero
    assign unused_cnt_bits = ^{pix_cnt, w_cnt};

    // Sequencer: snapshot capture, bit presentation, done pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            snap_p   <= '0;
            snap_w   <= '0;
            pix_last <= 1'b0;
            w_last   <= 1'b0;
            ready    <= 1'b1;
            en_wr    <= 1'b0;
            dout_p   <= 1'b0;
            dout_w   <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    en_wr    <= 1'b0;
                    dout_p   <= 1'b0;
                    dout_w   <= 1'b0;
                    done     <= 1'b0;
                    pix_last <= 1'b0;
                    w_last   <= 1'b0;
                    if (start_ok) begin
                        snap_p <= pixels_in;
                        snap_w <= weights_in;
                        state  <= SHIFT;
                        ready  <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        ready  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (pix_last) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        ready  <= 1'b1;
                        en_wr  <= 1'b0;
                        dout_p <= 1'b0;
                        dout_w <= 1'b0;
                    end else if (hold) begin
                        en_wr  <= 1'b0;
                    end else begin
                        en_wr  <= 1'b1;
                        dout_p <= snap_p[row][col];
                        dout_w <= w_last ? 1'b0 : snap_w[lvl][trit][bit_i];
                        if (pix_term) pix_last <= 1'b1;
                        if (w_term)   w_last   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed-plus-random bench for frame_serializer. Expected bits come from the
// stream-index arithmetic of the load order (i -> r,c and i -> l,t,b).
module tb_frame_serializer;
    import bnn_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    pixel_frame_t pixels_in = '0;
    weight_set_t  weights_in = '0;
    logic         ready, en_wr, dout_p, dout_w, done;

    int n_tests = 0;
    int n_fail  = 0;
    int hold_left = 0;

    always #5 clk = ~clk;

    frame_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .hold       (hold),
        .pixels_in  (pixels_in),
        .weights_in (weights_in),
        .ready      (ready),
        .en_wr      (en_wr),
        .dout_p     (dout_p),
        .dout_w     (dout_w),
        .done       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pix(input pixel_frame_t f, input int i);
        return f[R_W'(i / COLS)][C_W'(i % COLS)];
    endfunction

    function automatic logic exp_wt(input weight_set_t w, input int i);
        if (i >= NW) return 1'b0;
        return w[L_W'(i / (K*K))][T_W'((i / K) % K)][B_W'(i % K)];
    endfunction

    function automatic pixel_frame_t rand_frame();
        pixel_frame_t f;
        for (int r = 0; r < ROWS; r++) f[R_W'(r)] = COLS'($urandom);
        return f;
    endfunction

    function automatic weight_set_t rand_weights();
        return NW'({$urandom, $urandom, $urandom});
    endfunction

    // Observe one frame starting the cycle after the accepting edge.
    task automatic run_frame(input string name, input pixel_frame_t ep, input weight_set_t ew,
                             input int hold_after, input int hold_len,
                             input int poke_bit, input pixel_frame_t poke_p,
                             input int reset_bit, input int exp_first, input int exp_done);
        int nbits;
        int rel;
        int first;
        bit fin;
        nbits = 0;
        rel   = 0;
        first = -1;
        fin   = 1'b0;
        while (!fin && rel < 1200) begin
            if (hold_left > 0) hold_left--;
            else hold = 1'b0;
            step();
            start = 1'b0;
            rel++;
            if (rel == 1) chk({name, " ready_busy"}, ready, 0);
            if (done) begin
                chk({name, " done_cycle"}, rel, exp_done);
                chk({name, " bit_count"}, nbits, NPIX);
                chk({name, " first_bit_cycle"}, first, exp_first);
                chk({name, " done_en_wr"}, en_wr, 0);
                chk({name, " done_dout"}, {dout_p, dout_w}, 0);
                chk({name, " done_ready"}, ready, 1);
                fin = 1'b1;
            end else if (en_wr) begin
                if (first < 0) first = rel;
                if (nbits < NPIX) begin
                    chk($sformatf("%s p%0d", name, nbits), dout_p, exp_pix(ep, nbits));
                    chk($sformatf("%s w%0d", name, nbits), dout_w, exp_wt(ew, nbits));
                end
                if (nbits == hold_after) begin
                    hold = 1'b1;
                    hold_left = hold_len;
                end
                if (nbits == poke_bit) begin
                    pixels_in = poke_p;
                    start = 1'b1;
                end
                if (nbits == reset_bit) begin
                    reset_n = 1'b0;
                    step();
                    chk({name, " rst_en_wr"}, en_wr, 0);
                    chk({name, " rst_done"}, done, 0);
                    chk({name, " rst_ready"}, ready, 1);
                    chk({name, " rst_dout"}, {dout_p, dout_w}, 0);
                    reset_n = 1'b1;
                    fin = 1'b1;
                end
                nbits++;
            end
        end
        if (!fin) chk({name, " timeout"}, rel, exp_done);
    endtask

    initial begin
        pixel_frame_t cb, pa, pb;
        weight_set_t  wa, ws;
        int quiet_bad;

        // 1: reset
        reset_n = 1'b0;
        step();
        step();
        chk("reset ready", ready, 1);
        chk("reset en_wr", en_wr, 0);
        chk("reset dout_p", dout_p, 0);
        chk("reset dout_w", dout_w, 0);
        chk("reset done", done, 0);
        reset_n = 1'b1;
        step();

        // 2: checkerboard, no hold
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cb[R_W'(r)][C_W'(c)] = 1'((r ^ c) & 1);
        wa = rand_weights();
        pixels_in = cb;
        weights_in = wa;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("checker", cb, wa, -1, 0, -1, '0, -1, 1, 785);
        step();
        chk("checker done_one_cycle", done, 0);
        chk("checker idle_ready", ready, 1);

        // 3: single weight bit at [7][2][2]
        pa = rand_frame();
        ws = '0;
        ws[7][2][2] = 1'b1;
        pixels_in = pa;
        weights_in = ws;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("w722", pa, ws, -1, 0, -1, '0, -1, 1, 785);
        step();

        // 4: hold for 5 cycles after bit 100
        pa = rand_frame();
        wa = rand_weights();
        pixels_in = pa;
        weights_in = wa;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("hold", pa, wa, 100, 5, -1, '0, -1, 1, 790);
        step();

        // 5: start mid-stream ignored, then start in DONE chains with new inputs
        pa = rand_frame();
        pb = rand_frame();
        wa = rand_weights();
        pixels_in = pa;
        weights_in = wa;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("poke", pa, wa, -1, 0, 300, pb, -1, 1, 785);
        start = 1'b1;
        step();
        start = 1'b0;
        pixels_in = rand_frame();
        weights_in = rand_weights();
        run_frame("chain", pb, wa, -1, 0, -1, '0, -1, 1, 785);
        step();
        chk("chain done_one_cycle", done, 0);

        // 6: reset at bit 500, then replay from bit 0
        pa = rand_frame();
        wa = rand_weights();
        pixels_in = pa;
        weights_in = wa;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("abort", pa, wa, -1, 0, -1, '0, 500, 1, -1);
        quiet_bad = 0;
        repeat (10) begin
            step();
            if (done || en_wr || !ready) quiet_bad++;
        end
        chk("abort quiet_after_reset", quiet_bad, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("replay", pa, wa, -1, 0, -1, '0, -1, 1, 785);
        step();

        // 7: hold together with start in IDLE withholds the first bit
        pa = rand_frame();
        wa = rand_weights();
        pixels_in = pa;
        weights_in = wa;
        hold = 1'b1;
        hold_left = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("hold_start", pa, wa, -1, 0, -1, '0, -1, 4, 788);
        step();
        chk("final done_low", done, 0);
        chk("final ready", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
